lcd_ctrl: RTL and testbench

HD44780-compatible 4-bit LCD controller that replaces software bit-banging of the character LCD. The CPU writes 8-bit commands/data through a memory-mapped IO strobe; the block queues them, splits each byte into two nibbles, and generates E/RS/DB timing plus per-command execution waits. It sits between the MCU's IO write decode and the `lcd_e`/`lcd_rw`/`lcd_rs`/`lcd_db` board pins.

---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_cmd_fifo.sv | 66 ++++++
 rtl/lcd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit LCD controller: FSM state
// enum, queued entry layout, the clear/home predicate and the init sequence.
package lcd_pkg;

  // Wide enough for the longest wait (power-up, ~405k cycles at 27 MHz).
  localparam int unsigned CntW    = 19;
  localparam int unsigned InitLen = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetH,
    StEhH,
    StElH,
    StSetL,
    StEhL,
    StWait
  } state_e;

  // One queued write: nib = send high nibble only, rs = data/command select.
  typedef struct packed {
    logic       nib;
    logic       rs;
    logic [7:0] data;
  } entry_t;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_clear_home(entry_t ent);
    return !ent.nib && !ent.rs &&
           (ent.data == 8'h01 || ent.data == 8'h02 || ent.data == 8'h03);
  endfunction

  // Power-on 4-bit init sequence: three 0x3 wake-ups, switch to 4-bit, then
  // function set, display on, clear, entry mode.
  function automatic entry_t init_rom(logic [2:0] idx);
    entry_t ent;
    case (idx)
      3'd0:    ent = '{nib: 1'b1, rs: 1'b0, data: 8'h30};
      3'd1:    ent = '{nib: 1'b1, rs: 1'b0, data: 8'h30};
      3'd2:    ent = '{nib: 1'b1, rs: 1'b0, data: 8'h30};
      3'd3:    ent = '{nib: 1'b1, rs: 1'b0, data: 8'h20};
      3'd4:    ent = '{nib: 1'b0, rs: 1'b0, data: 8'h28};
      3'd5:    ent = '{nib: 1'b0, rs: 1'b0, data: 8'h0C};
      3'd6:    ent = '{nib: 1'b0, rs: 1'b0, data: 8'h01};
      default: ent = '{nib: 1'b0, rs: 1'b0, data: 8'h06};
    endcase
    return ent;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command queue for the LCD controller. Synchronous FIFO with registered
// full/empty flags; the head entry comes straight from the storage flops.
// Depth must be a power of two, at least 2.
module lcd_cmd_fifo import lcd_pkg::*; #(
  parameter int unsigned Depth = 4
) (
  input  logic   sys_clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(Depth);

  entry_t          mem_q [Depth];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q, count_d;
  logic            full_q, empty_q;
  logic            do_push, do_pop;

  // A push is judged against the registered full flag, so a same-cycle pop
  // never makes room for it.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-compatible 4-bit LCD write controller. Queues CPU writes, splits
// bytes into nibbles and generates RS/DB/E timing plus execution waits.
// Define LCD_CTRL_INIT_EN to run the power-on init sequence from reset.
module lcd_ctrl import lcd_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_E_HIGH   = 13,
  parameter int unsigned T_E_LOW    = 27,
  parameter int unsigned T_EXEC     = 1080,
  parameter int unsigned T_CLEAR    = 44280,
  parameter int unsigned T_POWERUP  = 405000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       wr_rs,
  input  logic       wr_nib,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       full,
  output logic       ovf,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

`ifdef LCD_CTRL_INIT_EN
  localparam bit InitEn = 1'b1;
`else
  localparam bit InitEn = 1'b0;
`endif

  // Counter load for a state lasting v cycles.
  function automatic logic [CntW-1:0] ld(int unsigned v);
    return CntW'(v - 1);
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  entry_t          cur_q, cur_d;
  logic            long_q, long_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [3:0]      db_q, db_d;
  logic            ovf_q;

  entry_t          wr_entry, fifo_rdata, src;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic            cnt_done;
  logic [CntW-1:0] wait_ld;
  logic            init_active_q;
  logic [2:0]      init_idx_q;

  assign wr_entry = '{nib: wr_nib, rs: wr_rs, data: wr_data};

  lcd_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .push    (wr),
    .pop     (fifo_pop),
    .wdata   (wr_entry),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef LCD_CTRL_INIT_EN
  // Walk the init ROM one entry per IDLE visit; user entries wait until done.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      init_active_q <= 1'b1;
      init_idx_q    <= '0;
    end else if (state_q == StIdle && init_active_q) begin
      init_idx_q <= init_idx_q + 3'd1;
      if (init_idx_q == 3'(InitLen - 1)) init_active_q <= 1'b0;
    end
  end
`else
  assign init_active_q = 1'b0;
  assign init_idx_q    = '0;
`endif

  assign src      = init_active_q ? init_rom(init_idx_q) : fifo_rdata;
  assign cnt_done = (cnt_q == '0);
  assign wait_ld  = long_q ? ld(T_CLEAR) : ld(T_EXEC);

  // Next-state, timer and pin logic for the nibble sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    long_d   = long_q;
    e_d      = e_q;
    rs_d     = rs_q;
    db_d     = db_q;
    fifo_pop = 1'b0;
    if (!cnt_done) cnt_d = cnt_q - CntW'(1);
    unique case (state_q)
      StIdle: begin
        if (init_active_q || !fifo_empty) begin
          cur_d    = src;
          // Init wake-up nibbles also need the long settle time.
          long_d   = is_clear_home(src) || (init_active_q && src.nib);
          rs_d     = src.rs;
          db_d     = src.data[7:4];
          cnt_d    = ld(T_SETUP);
          fifo_pop = !init_active_q;
          state_d  = StSetH;
        end
      end
      StSetH: begin
        if (cnt_done) begin
          e_d     = 1'b1;
          cnt_d   = ld(T_E_HIGH);
          state_d = StEhH;
        end
      end
      StEhH: begin
        if (cnt_done) begin
          e_d = 1'b0;
          if (cur_q.nib) begin
            cnt_d   = wait_ld;
            state_d = StWait;
          end else begin
            db_d    = cur_q.data[3:0];
            cnt_d   = ld(T_E_LOW);
            state_d = StElH;
          end
        end
      end
      StElH: begin
        if (cnt_done) begin
          cnt_d   = ld(T_SETUP);
          state_d = StSetL;
        end
      end
      StSetL: begin
        if (cnt_done) begin
          e_d     = 1'b1;
          cnt_d   = ld(T_E_HIGH);
          state_d = StEhL;
        end
      end
      StEhL: begin
        if (cnt_done) begin
          e_d     = 1'b0;
          cnt_d   = wait_ld;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_done) state_d = StIdle;
      end
      default: begin
        e_d     = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state and registered LCD pins; reset drops E immediately.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= InitEn ? StWait : StIdle;
      cnt_q   <= InitEn ? ld(T_POWERUP) : '0;
      cur_q   <= '0;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      long_q  <= long_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
    end
  end

  // Sticky overflow: a write was dropped because the queue was full.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (wr && fifo_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign busy   = (state_q != StIdle) || !fifo_empty || init_active_q;
  assign full   = fifo_full;
  assign ovf    = ovf_q;
  assign lcd_e  = e_q;
  assign lcd_rw = 1'b0;
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: directed timing cases plus random bursts,
// checked by a monitor against an expected-pulse queue built from each write.
module tb_lcd_ctrl;

  localparam int TSetup = 2;
  localparam int TEHigh = 13;
  localparam int TELow  = 27;
  localparam int TExec  = 1080;
  localparam int TClear = 44280;
`ifdef LCD_CTRL_INIT_EN
  localparam int RstBusy = 1;
`else
  localparam int RstBusy = 0;
`endif

  logic       sys_clk;
  logic       rst_n;
  logic       wr, wr_rs, wr_nib;
  logic [7:0] wr_data;
  logic       busy, full, ovf, lcd_e, lcd_rw, lcd_rs;
  logic [3:0] lcd_db;

  lcd_ctrl dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .wr_rs   (wr_rs),
    .wr_nib  (wr_nib),
    .wr_data (wr_data),
    .busy    (busy),
    .full    (full),
    .ovf     (ovf),
    .lcd_e   (lcd_e),
    .lcd_rw  (lcd_rw),
    .lcd_rs  (lcd_rs),
    .lcd_db  (lcd_db)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: each write becomes one or two expected E pulses, with the
  // minimum (or exact) gap from the previous E fall to this pulse's rise.
  typedef struct {
    logic       rs;
    logic [3:0] db;
    bit         first;
    int         min_gap;
  } pulse_t;

  pulse_t exp_q[$];
  bit     have_last = 0;
  int     last_wait = 0;

  task automatic model_add(input logic rs, input logic nib, input logic [7:0] data,
                           input bit init_nib);
    pulse_t p;
    bit     long_w;
    long_w    = init_nib || (!rs && !nib && (data == 8'h01 || data == 8'h02 || data == 8'h03));
    p.rs      = rs;
    p.db      = data[7:4];
    p.first   = 1'b1;
    p.min_gap = have_last ? last_wait + 1 + TSetup : 0;
    exp_q.push_back(p);
    if (!nib) begin
      p.db      = data[3:0];
      p.first   = 1'b0;
      p.min_gap = TELow + TSetup;
      exp_q.push_back(p);
    end
    last_wait = long_w ? TClear : TExec;
    have_last = 1'b1;
  endtask

  // Monitor: sampled on the falling clock edge.
  int         cyc = 0;
  int         rise_cyc, last_fall, gap_last, pulses;
  bit         e_prev, have_fall;
  logic       rs_at_rise;
  logic [3:0] db_at_rise;

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    pulses = 0; e_prev = 0; have_fall = 0; gap_last = 0; last_fall = 0; rise_cyc = 0;
  end

  always @(negedge sys_clk) begin : mon
    pulse_t p;
    if (!rst_n) begin
      e_prev    = 1'b0;
      have_fall = 1'b0;
      exp_q.delete();
    end else begin
      if (lcd_e && !e_prev) begin
        rise_cyc   = cyc;
        rs_at_rise = lcd_rs;
        db_at_rise = lcd_db;
        check_eq("pulse_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          p = exp_q[0];
          check_eq("pulse_rs", lcd_rs, p.rs);
          check_eq("pulse_db", lcd_db, p.db);
          if (have_fall && !p.first) check_eq("nibble_gap", cyc - last_fall, p.min_gap);
          if (have_fall && p.first) begin
            gap_last = cyc - last_fall;
            if (p.min_gap > 0) check_eq("entry_gap_min", gap_last >= p.min_gap, 1);
          end
        end
      end else if (lcd_e && e_prev) begin
        check_eq("db_stable_while_e", {lcd_rs, lcd_db}, {rs_at_rise, db_at_rise});
      end else if (!lcd_e && e_prev) begin
        check_eq("e_high_width", cyc - rise_cyc, TEHigh);
        check_eq("rw_low", lcd_rw, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_fall = cyc;
        have_fall = 1'b1;
        pulses++;
      end
      e_prev = lcd_e;
    end
  end

  // Drive one write strobe; call at a falling edge, returns one cycle later.
  task automatic push_entry(input logic rs, input logic nib, input logic [7:0] data,
                            input bit accept);
    wr = 1'b1; wr_rs = rs; wr_nib = nib; wr_data = data;
    if (accept) model_add(rs, nib, data, 1'b0);
    @(negedge sys_clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      @(negedge sys_clk);
    end
    check_eq("reaches_idle", busy, 0);
  endtask

  task automatic wait_e_high(input int max);
    for (int i = 0; i < max; i++) begin
      if (lcd_e) break;
      @(negedge sys_clk);
    end
    check_eq("e_rises", lcd_e, 1);
  endtask

  initial begin
    #(1_000_000 + 6_000_000 * RstBusy);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rs_n, e_n, p0, len;
    logic r, nb;
    logic [7:0] d;

    rst_n = 1'b0; wr = 1'b0; wr_rs = 1'b0; wr_nib = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_e", lcd_e, 0);
    check_eq("rst_rw", lcd_rw, 0);
    check_eq("rst_rs", lcd_rs, 0);
    check_eq("rst_db", lcd_db, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_busy", busy, RstBusy);
    rst_n = 1'b1;
    @(negedge sys_clk);

`ifdef LCD_CTRL_INIT_EN
    model_add(1'b0, 1'b1, 8'h30, 1'b1);
    model_add(1'b0, 1'b1, 8'h30, 1'b1);
    model_add(1'b0, 1'b1, 8'h30, 1'b1);
    model_add(1'b0, 1'b1, 8'h20, 1'b1);
    model_add(1'b0, 1'b0, 8'h28, 1'b0);
    model_add(1'b0, 1'b0, 8'h0C, 1'b0);
    model_add(1'b0, 1'b0, 8'h01, 1'b0);
    model_add(1'b0, 1'b0, 8'h06, 1'b0);
    repeat (6) @(negedge sys_clk);
    push_entry(1'b1, 1'b0, 8'h5A, 1'b1);
    wait_idle(600_000);
    check_eq("init_all_emitted", exp_q.size(), 0);
    check_eq("init_pulse_count", pulses, 14);
    @(negedge sys_clk);
`endif

    // Data byte 0x41: latency from the sampling edge, then a queued follower.
    p0 = pulses;
    push_entry(1'b1, 1'b0, 8'h41, 1'b1);
    n = 1; rs_n = -1; e_n = -1;
    while (n < 20) begin
      if (rs_n < 0 && lcd_rs) rs_n = n;
      if (lcd_e) begin
        e_n = n;
        break;
      end
      @(negedge sys_clk);
      n++;
    end
    check_eq("rs_latency", rs_n, 2);
    check_eq("e_latency", e_n, 2 + TSetup);
    check_eq("first_db_high", lcd_db, 4'h4);
    push_entry(1'b1, 1'b0, 8'h42, 1'b1);
    wait_idle(5000);
    check_eq("exec_gap", gap_last >= TExec + 1 + TSetup && gap_last <= TExec + 2 + TSetup, 1);
    check_eq("busy_fall_exec", cyc - last_fall, TExec);
    check_eq("data_all_emitted", exp_q.size(), 0);
    check_eq("data_pulse_count", pulses - p0, 4);

    // Clear followed by set-DDRAM: long wait between them.
    push_entry(1'b0, 1'b0, 8'h01, 1'b1);
    push_entry(1'b0, 1'b0, 8'h80, 1'b1);
    wait_idle(50_000);
    check_eq("clear_gap", gap_last >= TClear + 1 + TSetup && gap_last <= TClear + 2 + TSetup, 1);
    check_eq("clear_all_emitted", exp_q.size(), 0);

    // Nibble mode: one pulse, then a normal execution wait.
    p0 = pulses;
    push_entry(1'b0, 1'b1, 8'h30, 1'b1);
    wait_idle(5000);
    check_eq("nib_one_pulse", pulses - p0, 1);
    check_eq("busy_fall_nib", cyc - last_fall, TExec);
    check_eq("nib_all_emitted", exp_q.size(), 0);

    // Random bursts (clear/home codes avoided to keep the run short).
    for (int b = 0; b < 5; b++) begin
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin
        r  = 1'($urandom_range(0, 1));
        nb = ($urandom_range(0, 3) == 0);
        d  = 8'($urandom);
        if (!r && !nb && (d == 8'h01 || d == 8'h02 || d == 8'h03)) d = d | 8'h10;
        push_entry(r, nb, d, 1'b1);
      end
      wait_idle(8000);
      check_eq("rand_all_emitted", exp_q.size(), 0);
    end

    // Overflow: transfer in flight, then five back-to-back writes into depth 4.
    check_eq("ovf_clear_before", ovf, 0);
    p0 = pulses;
    push_entry(1'b1, 1'b0, 8'h41, 1'b1);
    wait_e_high(100);
    for (int i = 0; i < 5; i++) begin
      push_entry(1'b1, 1'b0, 8'(8'h50 + i), i < 4);
      if (i == 2) check_eq("full_after_3", full, 0);
      if (i == 3) check_eq("full_after_4", full, 1);
    end
    check_eq("ovf_set", ovf, 1);
    check_eq("full_held", full, 1);
    wait_idle(10_000);
    check_eq("ovf_all_emitted", exp_q.size(), 0);
    check_eq("ovf_pulse_count", pulses - p0, 10);
    check_eq("ovf_sticky", ovf, 1);

    // Reset during the first E-high with more work queued.
    p0 = pulses;
    push_entry(1'b1, 1'b0, 8'h55, 1'b1);
    push_entry(1'b1, 1'b0, 8'h66, 1'b1);
    wait_e_high(100);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_e", lcd_e, 0);
    check_eq("rst_mid_ovf", ovf, 0);
    check_eq("rst_mid_full", full, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    have_last = 1'b0;
    repeat (3000) @(negedge sys_clk);
    check_eq("rst_no_pulses", pulses - p0, 0);
    check_eq("rst_busy_after", busy, RstBusy);
    check_eq("rst_e_after", lcd_e, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
